// File: rtl/scaler_nx.sv
// scaler_nx: integer pixel-replication scaler (1x..4x) with optional scanline dimming.
// Each input line is captured into a ping-pong line buffer. Each output row
// replicates every buffered pixel (scale+1) times. Every buffered line is shown
// on (scale+1) consecutive output rows.
// Ports:
//   clk, reset              single clock; asynchronous active-high reset
//   ce_in, de_in            input pixel enable / input active video
//   inputpixel [3*CHW]      input pixel, R in the low bits, B in the high bits
//   ce_out, hblank          output pixel enable / output horizontal blank
//   reset_frame             output frame start; restarts vertical replication
//   scale [2]               replication factor minus one, clamped to MAXSCALE-1
//   scanline [2]            dim mode for the last replicated row (0 off, 1 75%, 2 50%, 3 25%)
//   outpixel [3*CHW], out_de  output pixel, and the flag that it carries line data
module scaler_nx #(
    parameter int unsigned LENGTH   = 1024,
    parameter int unsigned CHW      = 8,
    parameter int unsigned MAXSCALE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce_in,
    input  logic                 de_in,
    input  logic [3*CHW-1:0]     inputpixel,
    input  logic                 ce_out,
    input  logic                 hblank,
    input  logic                 reset_frame,
    input  logic [1:0]           scale,
    input  logic [1:0]           scanline,
    output logic [3*CHW-1:0]     outpixel,
    output logic                 out_de
);

    localparam int unsigned PW = 3 * CHW;
    localparam int unsigned XW = $clog2(LENGTH + 1);
    localparam int unsigned MW = $clog2(2 * LENGTH);
    localparam logic [1:0]  SMAX = 2'(MAXSCALE - 1);

    // Both line buffers live in one RAM; the bank bit selects the upper half.
    logic [PW-1:0] mem [2*LENGTH];
    logic [PW-1:0] rd_data;

    logic [XW-1:0] wr_x, cmtlen, rdlen, read_x;
    logic          wrbuf, cmtbuf, rdbuf;
    logic          de_prev, armed;
    logic [1:0]    hrep, vrep, scale_l, scan_l;
    logic          hb_prev, ce_d, pend_valid;
    logic [1:0]    pend_dim;

    logic          wr_en_c, commit_c, hb_fall_c, hb_rise_c, latch_c;
    logic          rd_bank_c, rd_valid_c;
    logic [XW-1:0] rd_len_c;
    logic [1:0]    scale_in_c, cur_scale_c, cur_scan_c, dim_c;
    logic [MW-1:0] rd_addr_c, wr_addr_c;

    function automatic logic [MW-1:0] buf_addr(input logic bank, input logic [XW-1:0] x);
        return (bank ? MW'(LENGTH) : MW'(0)) + MW'(x);
    endfunction

    // Per-channel dimming; each channel is shifted independently so no carry crosses channels.
    function automatic logic [PW-1:0] dim(input logic [PW-1:0] p, input logic [1:0] mode);
        logic [PW-1:0]  r;
        logic [CHW-1:0] c;
        r = p;
        for (int i = 0; i < 3; i++) begin
            c = p[i*CHW +: CHW];
            case (mode)
                2'd1:    c = c - (c >> 2);
                2'd2:    c = c >> 1;
                2'd3:    c = c >> 2;
                default: c = c;
            endcase
            r[i*CHW +: CHW] = c;
        end
        return r;
    endfunction

    // Write/commit qualifiers and read-side decode for the current ce_out.
    always_comb begin
        wr_en_c     = 1'b0;
        commit_c    = 1'b0;
        hb_fall_c   = 1'b0;
        hb_rise_c   = 1'b0;
        latch_c     = 1'b0;
        scale_in_c  = (scale > SMAX) ? SMAX : scale;
        cur_scale_c = scale_l;
        cur_scan_c  = scan_l;
        rd_bank_c   = rdbuf;
        rd_len_c    = rdlen;
        rd_valid_c  = 1'b0;
        dim_c       = 2'd0;

        wr_en_c   = ce_in & armed & de_in & (wr_x < XW'(LENGTH));
        commit_c  = ce_in & armed & ~de_in & de_prev;
        hb_fall_c = ce_out & ~hblank & hb_prev;
        hb_rise_c = ce_out & hblank & ~hb_prev;
        latch_c   = hb_fall_c & (vrep == 2'd0);

        // On the first active ce_out the freshly latched line and settings apply at once.
        if (hb_fall_c) begin
            cur_scale_c = scale_in_c;
            cur_scan_c  = scanline;
        end
        if (latch_c) begin
            rd_bank_c = cmtbuf;
            rd_len_c  = cmtlen;
        end
        rd_valid_c = ~hblank & (read_x < rd_len_c);
        if ((vrep == cur_scale_c) && (cur_scale_c != 2'd0))
            dim_c = cur_scan_c;

        rd_addr_c = buf_addr(rd_bank_c, read_x);
        wr_addr_c = buf_addr(wrbuf, wr_x);
    end

    // Buffer RAM: synchronous write, registered read issued on ce_out.
    always_ff @(posedge clk) begin
        if (wr_en_c)
            mem[wr_addr_c] <= inputpixel;
        if (ce_out && rd_valid_c)
            rd_data <= mem[rd_addr_c];
    end

    // Input side: fill wrbuf, commit on the falling edge of de_in.
    // armed stays low until de_in has been seen low, so a line that is in progress when reset is released is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_x    <= '0;
            cmtlen  <= '0;
            wrbuf   <= 1'b0;
            cmtbuf  <= 1'b0;
            de_prev <= 1'b0;
            armed   <= 1'b0;
        end else if (ce_in) begin
            de_prev <= de_in;
            if (!de_in)
                armed <= 1'b1;
            if (wr_en_c)
                wr_x <= wr_x + XW'(1);
            if (commit_c) begin
                cmtlen <= wr_x;
                cmtbuf <= wrbuf;
                wrbuf  <= ~wrbuf;
                wr_x   <= '0;
            end
        end
    end

    // Output side: horizontal/vertical replication counters and line latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_x     <= '0;
            hrep       <= 2'd0;
            vrep       <= 2'd0;
            rdlen      <= '0;
            rdbuf      <= 1'b0;
            hb_prev    <= 1'b1;
            scale_l    <= 2'd0;
            scan_l     <= 2'd0;
            pend_valid <= 1'b0;
            pend_dim   <= 2'd0;
            ce_d       <= 1'b0;
        end else begin
            ce_d <= ce_out;
            if (ce_out) begin
                hb_prev <= hblank;
                if (reset_frame)
                    vrep <= 2'd0;
                else if (hb_rise_c)
                    vrep <= (vrep >= scale_l) ? 2'd0 : vrep + 2'd1;
                if (hb_fall_c) begin
                    scale_l <= scale_in_c;
                    scan_l  <= scanline;
                end
                if (latch_c) begin
                    rdbuf <= cmtbuf;
                    rdlen <= cmtlen;
                end
                pend_valid <= rd_valid_c;
                pend_dim   <= dim_c;
                if (hblank) begin
                    read_x <= '0;
                    hrep   <= 2'd0;
                end else if (rd_valid_c) begin
                    if (hrep >= cur_scale_c) begin
                        hrep   <= 2'd0;
                        read_x <= read_x + XW'(1);
                    end else begin
                        hrep <= hrep + 2'd1;
                    end
                end
            end
        end
    end

    // Output register, loaded the clk after ce_out when the RAM data is available.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outpixel <= '0;
            out_de   <= 1'b0;
        end else if (ce_d) begin
            outpixel <= pend_valid ? dim(rd_data, pend_dim) : '0;
            out_de   <= pend_valid;
        end
    end

endmodule
